exstage: RTL and testbench
==========================

# exstage

Execute stage of the five-stage in-order pipeline (IF, ID, EX, MA, WB). It sits directly downstream of the decode stage. It latches the 151-bit decoded-instruction bus and computes the ALU result. It issues the data-SRAM request for loads and stores, reports its destination register back to decode for hazard detection, and hands a 71-bit result bus to the memory-access stage under the valid/allowin handshake.

## Interface
Parameters: none. All widths are fixed by the bus formats.

- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `id_validout`  in  1  decode holds a valid instruction that is ready to leave.
- `ma_allowin`  in  1  memory-access stage can accept an instruction this cycle.
- `ex_allowin`  out  1  EX can accept an instruction this cycle.
- `ex_validout`  out  1  EX holds a valid, completed instruction for MA.
- `id_to_ex_bus`  in  151  decoded-instruction bus. Field layout, MSB to LSB:
  - alu_op[150:139]
  - load_op[138]
  - src1_is_pc[137]
  - src2_is_imm[136]
  - gr_we[135]
  - mem_we[134]
  - dest[133:129]
  - imm[128:97]
  - rj_value[96:65]
  - rkd_value[64:33]
  - pc[32:1]
  - res_from_mem[0]
- `ex_to_ma_bus`  out  71  result bus. Field layout, MSB to LSB:
  - res_from_mem[70]
  - gr_we[69]
  - dest[68:64]
  - alu_result[63:32]
  - pc[31:0]
- `ex_to_id_bus`  out  6  hazard report {gr_we & valid, dest}.
- `data_sram_en`  out  1  data-SRAM enable.
- `data_sram_we`  out  4  byte write enables.
- `data_sram_addr`  out  32  byte address (alu_result).
- `data_sram_wdata`  out  32  store data (rkd_value).

## Operation
- **State.** EX holds two registers:
  - `valid` (1 bit)
  - `id_to_ex_bus_r` (151 bits)
- **Handshake.**
  - readygo = 1; every operation completes in one cycle.
  - ex_allowin = ~valid | (readygo & ma_allowin).
  - ex_validout = valid & readygo.
- **Valid register.** When ex_allowin = 1, valid <= id_validout. When ex_allowin = 0, valid holds.
- **Bus register.** Loads id_to_ex_bus only when id_validout & ex_allowin. Otherwise it holds, so its contents stay stable during a stall.
- **Operand selection.**
  - src1 = src1_is_pc ? pc : rj_value.
  - src2 = src2_is_imm ? imm : rkd_value.
- **ALU.** alu_op is one-hot. The result is the OR of the gated per-op results, so an all-zero alu_op gives alu_result = 0.
  - [0] add: src1 + src2, modulo 2^32, overflow ignored.
  - [1] sub: src1 - src2, modulo 2^32.
  - [2] slt: signed src1 < src2 gives {31'b0, 1}; otherwise 0.
  - [3] sltu: same as slt, but the comparison is unsigned.
  - [4] and.
  - [5] nor.
  - [6] or.
  - [7] xor.
  - [8] sll: src1 << src2[4:0].
  - [9] srl: logical right shift of src1 by src2[4:0].
  - [10] sra: arithmetic right shift of src1 by src2[4:0].
  - [11] lui: result = src2. imm already carries {si20, 12'b0}.
  - Shifts use only src2[4:0]; src2[31:5] is ignored.
- **Data SRAM.**
  - data_sram_en = valid.
  - data_sram_we = (mem_we & valid) ? 4'hF : 4'h0.
  - data_sram_addr = alu_result.
  - data_sram_wdata = rkd_value.
  - Only word access is supported. Address alignment is not checked.
- **Hazard report.** ex_to_id_bus[5] = gr_we & valid, so a bubble never reports a destination. dest is passed through unchanged, including dest = 0. Decode masks r0.
- **Result bus.** ex_to_ma_bus is driven from the registered fields and the current alu_result. MA qualifies it with ex_validout.

## Timing
- **Reset.** Takes effect on the clock edge where rst = 1.
  - valid = 0 and id_to_ex_bus_r = 0.
  - Consequently: ex_allowin = 1, ex_validout = 0, ex_to_id_bus = 6'b0, ex_to_ma_bus = 0.
  - data_sram_en = 0, data_sram_we = 0, data_sram_addr = 0, data_sram_wdata = 0.
- **Reset mid-operation.** rst dominates all other inputs. Any held instruction is dropped at that edge, including a store stalled by ma_allowin = 0. No SRAM write is issued in the cycle after that edge.
- **Latency.** An instruction accepted at edge N is presented to MA during cycle N..N+1. It moves to MA at the first edge where ma_allowin = 1.
- **Read timing.** The SRAM read is synchronous. The address is issued in the EX cycle and read data appears in MA the next cycle.
- **Stall.** While valid & ~ma_allowin:
  - ex_allowin = 0, and the bus register and all outputs hold.
  - A store keeps write-enable asserted with identical address and data. This rewrite is idempotent and allowed.
- **Simultaneous events.**
  - ma_allowin = 1 with id_validout = 1: back-to-back transfer with no bubble.
  - ma_allowin = 1 with id_validout = 0: valid falls to 0.
- **Flushes.** A branch in decode only squashes the instruction upstream of decode. EX has no flush input.
- **Combinational paths.**
  - ma_allowin to ex_allowin is purely combinational.
  - There is no combinational path from id_to_ex_bus to any output.

## Test plan
1. **Reset.** Hold rst for 2 cycles with id_validout = 1. Required: ex_validout = 0, ex_allowin = 1, data_sram_we = 0, ex_to_id_bus = 0 throughout. The first instruction is accepted on the edge after rst falls.
2. **ALU sweep.** One instruction per op, with ma_allowin = 1 and back-to-back issue. Required one-cycle results:
   - add 0x7FFFFFFF + 1 = 0x80000000.
   - sub 0 - 1 = 0xFFFFFFFF.
   - slt 0xFFFFFFFF vs 1 = 1; sltu on the same operands = 0.
   - nor 0 vs 0 = 0xFFFFFFFF.
   - sra 0x80000000 by 0x21 = 0xC0000000 (shift amount 1; bits 31:5 of src2 ignored).
   - lui with imm 0x12345000 = 0x12345000.
3. **PC-relative link.** src1_is_pc = 1, pc = 0x1C000010, imm = 4, alu_op[0] = 1 -> alu_result = 0x1C000014, dest = 1, gr_we = 1.
4. **Store under stall.**
   - Stimulus: store with rj = 0x100, imm = 0x8, rkd = 0xDEADBEEF; ma_allowin held at 0 for 3 cycles.
   - Required: data_sram_we = 4'hF, addr = 0x108, wdata = 0xDEADBEEF held stable; ex_allowin = 0.
   - When ma_allowin rises, the next instruction is accepted on that edge.
5. **Bubble hazard report.** id_validout = 0 while the register holds a stale gr_we = 1, dest = 5 -> ex_to_id_bus[5] = 0 and data_sram_we = 0.
6. **Reset during a stalled load.** Assert rst for 1 cycle -> ex_validout = 0 and data_sram_en = 0 on the next cycle. No residual result reaches MA.

Source files
------------

// File: rtl/exstage.sv
// Execute stage: latches the decoded instruction, computes the ALU result and issues the data-SRAM request.
// One-cycle latency; a stalled instruction holds its bus register and all outputs until ma_allowin rises.
module exstage (
    input  logic         clk,
    input  logic         rst,
    input  logic         id_validout,
    input  logic         ma_allowin,
    output logic         ex_allowin,
    output logic         ex_validout,
    input  logic [150:0] id_to_ex_bus,
    output logic [70:0]  ex_to_ma_bus,
    output logic [5:0]   ex_to_id_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata
);

    logic         valid;
    logic [150:0] id_to_ex_bus_r;
    logic         readygo;

    logic [11:0]  alu_op;
    logic         load_op;
    logic         src1_is_pc;
    logic         src2_is_imm;
    logic         gr_we;
    logic         mem_we;
    logic [4:0]   dest;
    logic [31:0]  imm;
    logic [31:0]  rj_value;
    logic [31:0]  rkd_value;
    logic [31:0]  pc;
    logic         res_from_mem;

    logic [31:0]  src1;
    logic [31:0]  src2;
    logic [4:0]   shamt;
    logic [31:0]  alu_result;

    assign readygo     = 1'b1;
    assign ex_allowin  = ~valid | (readygo & ma_allowin);
    assign ex_validout = valid & readygo;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid          <= 1'b0;
            id_to_ex_bus_r <= '0;
        end else begin
            if (ex_allowin)
                valid <= id_validout;
            if (id_validout & ex_allowin)
                id_to_ex_bus_r <= id_to_ex_bus;
        end
    end

    assign {alu_op, load_op, src1_is_pc, src2_is_imm, gr_we, mem_we, dest,
            imm, rj_value, rkd_value, pc, res_from_mem} = id_to_ex_bus_r;

    assign src1  = src1_is_pc  ? pc  : rj_value;
    assign src2  = src2_is_imm ? imm : rkd_value;
    assign shamt = src2[4:0];

    // One-hot op select; an all-zero alu_op yields zero.
    always_comb begin
        alu_result = '0;
        if (alu_op[0])  alu_result = alu_result | (src1 + src2);
        if (alu_op[1])  alu_result = alu_result | (src1 - src2);
        if (alu_op[2])  alu_result = alu_result | {31'b0, $signed(src1) < $signed(src2)};
        if (alu_op[3])  alu_result = alu_result | {31'b0, src1 < src2};
        if (alu_op[4])  alu_result = alu_result | (src1 & src2);
        if (alu_op[5])  alu_result = alu_result | ~(src1 | src2);
        if (alu_op[6])  alu_result = alu_result | (src1 | src2);
        if (alu_op[7])  alu_result = alu_result | (src1 ^ src2);
        if (alu_op[8])  alu_result = alu_result | (src1 << shamt);
        if (alu_op[9])  alu_result = alu_result | (src1 >> shamt);
        if (alu_op[10]) alu_result = alu_result | 32'($signed(src1) >>> shamt);
        if (alu_op[11]) alu_result = alu_result | src2;
    end

    assign data_sram_en    = valid;
    assign data_sram_we    = (mem_we & valid) ? 4'hF : 4'h0;
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rkd_value;

    // Bubbles never report a destination; r0 masking is left to decode.
    assign ex_to_id_bus = {gr_we & valid, dest};
    assign ex_to_ma_bus = {res_from_mem, gr_we, dest, alu_result, pc};

    logic unused_load_op;
    assign unused_load_op = load_op;

endmodule

// File: tb/tb_exstage.sv
// Self-checking bench for exstage: directed scenarios plus a randomized run against a behavioural model.
module tb_exstage;

    logic         clk;
    logic         rst;
    logic         id_validout;
    logic         ma_allowin;
    logic         ex_allowin;
    logic         ex_validout;
    logic [150:0] id_to_ex_bus;
    logic [70:0]  ex_to_ma_bus;
    logic [5:0]   ex_to_id_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    exstage dut (
        .clk(clk), .rst(rst), .id_validout(id_validout), .ma_allowin(ma_allowin),
        .ex_allowin(ex_allowin), .ex_validout(ex_validout), .id_to_ex_bus(id_to_ex_bus),
        .ex_to_ma_bus(ex_to_ma_bus), .ex_to_id_bus(ex_to_id_bus), .data_sram_en(data_sram_en),
        .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] op;
        logic        load, s1pc, s2imm, grwe, memwe;
        logic [4:0]  dest;
        logic [31:0] imm, rj, rkd, pc;
        logic        rfm;
    } ins_t;

    function automatic logic [150:0] pack(ins_t i);
        return {i.op, i.load, i.s1pc, i.s2imm, i.grwe, i.memwe, i.dest,
                i.imm, i.rj, i.rkd, i.pc, i.rfm};
    endfunction

    function automatic ins_t mk(int op, logic [31:0] rj, logic [31:0] rkd, logic [31:0] imm, logic s2imm);
        ins_t i;
        i.op = (op >= 0 && op < 12) ? 12'(1 << op) : 12'h000;
        i.load = 1'b0; i.s1pc = 1'b0; i.s2imm = s2imm; i.grwe = 1'b0; i.memwe = 1'b0;
        i.dest = 5'd0; i.imm = imm; i.rj = rj; i.rkd = rkd; i.pc = 32'h1C00_0000; i.rfm = 1'b0;
        return i;
    endfunction

    // Reference ALU expressed from the operation definitions.
    function automatic logic [31:0] ref_alu(ins_t i);
        logic [31:0] a, b, r;
        logic [63:0] ext;
        int sh;
        a = i.s1pc ? i.pc : i.rj;
        b = i.s2imm ? i.imm : i.rkd;
        sh = int'(b % 32);
        ext = {{32{a[31]}}, a} >> sh;
        r = 32'h0;
        if (i.op[0])  r = r | (a + b);
        if (i.op[1])  r = r | (a + ~b + 32'd1);
        if (i.op[2])  r = r | (((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0);
        if (i.op[3])  r = r | ((a < b) ? 32'd1 : 32'd0);
        if (i.op[4])  r = r | (a & b);
        if (i.op[5])  r = r | ~(a | b);
        if (i.op[6])  r = r | (a | b);
        if (i.op[7])  r = r | (a ^ b);
        if (i.op[8])  r = r | 32'(a * (64'd1 << sh));
        if (i.op[9])  r = r | 32'(a / (64'd1 << sh));
        if (i.op[10]) r = r | ext[31:0];
        if (i.op[11]) r = r | b;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; id_validout = 1'b1; ma_allowin = 1'b1;
        id_to_ex_bus = pack(mk(0, 32'd1, 32'd2, 32'd0, 1'b0));
        for (int c = 0; c < 2; c++) begin
            tick();
            n_tests++;
            if (ex_validout !== 1'b0 || ex_allowin !== 1'b1 || data_sram_we !== 4'h0 ||
                ex_to_id_bus !== 6'h00 || ex_to_ma_bus !== 71'h0 || data_sram_en !== 1'b0 ||
                data_sram_addr !== 32'h0 || data_sram_wdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_state cyc=%0d: vout=%b allow=%b we=%h to_id=%h to_ma=%h en=%b addr=%h wdata=%h, required all zero except allow=1",
                         c, ex_validout, ex_allowin, data_sram_we, ex_to_id_bus, ex_to_ma_bus,
                         data_sram_en, data_sram_addr, data_sram_wdata);
            end
        end
        rst = 1'b0;
        #2;
        n_tests++;
        if (ex_validout !== 1'b0 || ex_allowin !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_pre: vout=%b allow=%b, required 0/1", ex_validout, ex_allowin);
        end
        tick();
        n_tests++;
        if (ex_validout !== 1'b1 || ex_to_ma_bus[63:32] !== 32'd3) begin
            n_fail++;
            $display("FAIL reset_first_accept: vout=%b alu=%h, required 1/00000003", ex_validout, ex_to_ma_bus[63:32]);
        end
    endtask

    localparam int          SW_N = 13;
    localparam int          SW_OP  [SW_N] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
    localparam logic [31:0] SW_A   [SW_N] = '{32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_F0F0,
                                              32'h0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h1, 32'h8000_0000,
                                              32'h8000_0000, 32'h5555_5555, 32'h1234_5678};
    localparam logic [31:0] SW_B   [SW_N] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'hFF00_FF00, 32'h0, 32'hFF00_FF00,
                                              32'hFF00_FF00, 32'd31, 32'd4, 32'h21, 32'h12345000, 32'h9ABC_DEF0};
    localparam logic [31:0] SW_EXP [SW_N] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'hF000_F000,
                                              32'hFFFF_FFFF, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'h8000_0000,
                                              32'h0800_0000, 32'hC000_0000, 32'h1234_5000, 32'h0};

    task automatic test_alu_sweep();
        ins_t i;
        ma_allowin = 1'b1; id_validout = 1'b1;
        for (int k = 0; k < SW_N; k++) begin
            // lui takes its operand from imm; rkd is set to a decoy value.
            if (SW_OP[k] == 11) i = mk(11, SW_A[k], 32'hDEAD_0000, SW_B[k], 1'b1);
            else                i = mk(SW_OP[k], SW_A[k], SW_B[k], 32'hAAAA_AAAA, 1'b0);
            id_to_ex_bus = pack(i);
            tick();
            n_tests++;
            if (ex_validout !== 1'b1 || ex_to_ma_bus[63:32] !== SW_EXP[k] || data_sram_addr !== SW_EXP[k]) begin
                n_fail++;
                $display("FAIL alu_sweep op=%0d: vout=%b alu=%h addr=%h, required vout=1 result=%h",
                         SW_OP[k], ex_validout, ex_to_ma_bus[63:32], data_sram_addr, SW_EXP[k]);
            end
        end
    endtask

    task automatic test_pc_link();
        ins_t i;
        i = mk(0, 32'hFFFF_0000, 32'h0, 32'd4, 1'b1);
        i.s1pc = 1'b1; i.pc = 32'h1C00_0010; i.dest = 5'd1; i.grwe = 1'b1;
        ma_allowin = 1'b1; id_validout = 1'b1; id_to_ex_bus = pack(i);
        tick();
        n_tests++;
        if (ex_to_ma_bus !== {1'b0, 1'b1, 5'd1, 32'h1C00_0014, 32'h1C00_0010} || ex_to_id_bus !== 6'b100001) begin
            n_fail++;
            $display("FAIL pc_link: to_ma=%h to_id=%b, required alu=1C000014 dest=1 gr_we=1", ex_to_ma_bus, ex_to_id_bus);
        end
    endtask

    task automatic test_store_stall();
        ins_t st, nx;
        st = mk(0, 32'h100, 32'hDEAD_BEEF, 32'h8, 1'b1);
        st.memwe = 1'b1;
        nx = mk(6, 32'h55, 32'hAA, 32'h0, 1'b0);
        ma_allowin = 1'b1; id_validout = 1'b1; id_to_ex_bus = pack(st);
        tick();
        ma_allowin = 1'b0; id_to_ex_bus = pack(nx);
        for (int c = 0; c < 3; c++) begin
            #2;
            n_tests++;
            if (data_sram_we !== 4'hF || data_sram_addr !== 32'h108 || data_sram_wdata !== 32'hDEAD_BEEF ||
                ex_allowin !== 1'b0 || ex_validout !== 1'b1) begin
                n_fail++;
                $display("FAIL store_stall cyc=%0d: we=%h addr=%h wdata=%h allow=%b vout=%b, required F/00000108/DEADBEEF/0/1",
                         c, data_sram_we, data_sram_addr, data_sram_wdata, ex_allowin, ex_validout);
            end
            tick();
        end
        ma_allowin = 1'b1;
        #2;
        n_tests++;
        if (ex_allowin !== 1'b1) begin
            n_fail++;
            $display("FAIL store_release_allow: allow=%b, required 1", ex_allowin);
        end
        tick();
        n_tests++;
        if (ex_to_ma_bus[63:32] !== 32'hFF || data_sram_we !== 4'h0 || ex_validout !== 1'b1) begin
            n_fail++;
            $display("FAIL store_next_accept: alu=%h we=%h vout=%b, required 000000FF/0/1",
                     ex_to_ma_bus[63:32], data_sram_we, ex_validout);
        end
    endtask

    task automatic test_bubble();
        ins_t i;
        i = mk(0, 32'h40, 32'h1, 32'h0, 1'b0);
        i.grwe = 1'b1; i.dest = 5'd5; i.memwe = 1'b1;
        ma_allowin = 1'b1; id_validout = 1'b1; id_to_ex_bus = pack(i);
        tick();
        id_validout = 1'b0; id_to_ex_bus = '0;
        tick();
        n_tests++;
        if (ex_to_id_bus !== 6'b000101 || data_sram_we !== 4'h0 || ex_validout !== 1'b0 || data_sram_en !== 1'b0) begin
            n_fail++;
            $display("FAIL bubble_hazard: to_id=%b we=%h vout=%b en=%b, required 000101/0/0/0",
                     ex_to_id_bus, data_sram_we, ex_validout, data_sram_en);
        end
    endtask

    task automatic test_reset_stalled_load();
        ins_t i;
        i = mk(0, 32'h2000, 32'h0, 32'h10, 1'b1);
        i.load = 1'b1; i.rfm = 1'b1; i.grwe = 1'b1; i.dest = 5'd7;
        ma_allowin = 1'b1; id_validout = 1'b1; id_to_ex_bus = pack(i);
        tick();
        ma_allowin = 1'b0; id_validout = 1'b0;
        tick();
        n_tests++;
        if (ex_validout !== 1'b1 || data_sram_addr !== 32'h2010) begin
            n_fail++;
            $display("FAIL load_stall_held: vout=%b addr=%h, required 1/00002010", ex_validout, data_sram_addr);
        end
        rst = 1'b1; id_validout = 1'b1;
        tick();
        rst = 1'b0; id_validout = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_tests++;
            if (ex_validout !== 1'b0 || data_sram_en !== 1'b0 || data_sram_we !== 4'h0 ||
                ex_to_ma_bus !== 71'h0 || ex_to_id_bus !== 6'h0) begin
                n_fail++;
                $display("FAIL reset_stalled_load cyc=%0d: vout=%b en=%b we=%h to_ma=%h to_id=%h, required all zero",
                         c, ex_validout, data_sram_en, data_sram_we, ex_to_ma_bus, ex_to_id_bus);
            end
            tick();
        end
    endtask

    task automatic test_random();
        ins_t  cur, held;
        bit    occ;
        logic  e_allow;
        logic [31:0] e_alu;
        rst = 1'b1; id_validout = 1'b0; ma_allowin = 1'b0;
        tick();
        rst = 1'b0;
        occ = 1'b0;
        held = mk(-1, 32'h0, 32'h0, 32'h0, 1'b0);
        held.pc = 32'h0;
        for (int c = 0; c < 400; c++) begin
            cur = mk(int'($urandom_range(0, 12)), $urandom, $urandom, $urandom, 1'($urandom));
            cur.s1pc = 1'($urandom); cur.pc = $urandom; cur.grwe = 1'($urandom);
            cur.memwe = 1'($urandom); cur.load = 1'($urandom); cur.rfm = 1'($urandom);
            cur.dest = 5'($urandom);
            if ($urandom_range(0, 7) == 0) cur.rkd = cur.rkd | 32'hFFFF_FFE0;
            id_validout  = ($urandom_range(0, 9) < 7);
            ma_allowin   = ($urandom_range(0, 9) < 6);
            id_to_ex_bus = pack(cur);
            #2;
            e_allow = !occ || ma_allowin;
            e_alu   = ref_alu(held);
            n_tests++;
            if (ex_allowin !== e_allow || ex_validout !== occ || data_sram_en !== occ ||
                data_sram_we !== ((occ && held.memwe) ? 4'hF : 4'h0) ||
                data_sram_addr !== e_alu || data_sram_wdata !== held.rkd ||
                ex_to_id_bus !== {held.grwe && occ, held.dest} ||
                ex_to_ma_bus !== {held.rfm, held.grwe, held.dest, e_alu, held.pc}) begin
                n_fail++;
                $display("FAIL random cyc=%0d: allow=%b vout=%b we=%h addr=%h wdata=%h to_id=%h to_ma=%h; required allow=%b vout=%b we=%h addr=%h wdata=%h to_id=%h to_ma=%h",
                         c, ex_allowin, ex_validout, data_sram_we, data_sram_addr, data_sram_wdata,
                         ex_to_id_bus, ex_to_ma_bus, e_allow, occ,
                         (occ && held.memwe) ? 4'hF : 4'h0, e_alu, held.rkd,
                         {held.grwe && occ, held.dest}, {held.rfm, held.grwe, held.dest, e_alu, held.pc});
            end
            tick();
            if (e_allow) begin
                occ = id_validout;
                if (id_validout) held = cur;
            end
        end
    endtask

    initial begin
        rst = 1'b1; id_validout = 1'b0; ma_allowin = 1'b0; id_to_ex_bus = '0;
        test_reset();
        test_alu_sweep();
        test_pc_link();
        test_store_stall();
        test_bubble();
        test_reset_stalled_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
